// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone instruction-fetch block.
// WB_IFETCH_ERR_EN adds a fault bit to each buffered response.
package wb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_L = 4;
    localparam int DATA_W = DATA_L * 8;

    localparam logic [DATA_L-1:0] WB_SEL_ALL = '1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
`ifdef WB_IFETCH_ERR_EN
        logic              fault;
`endif
    } fetch_rsp_t;

    // Wide enough to hold every value from 0 to depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(DATA_L - 1);
    endfunction

endpackage

// File: rtl/wb_ifetch_if.sv
// Fetch-side bundle: redirect input, instruction output port and Wishbone read bus.
// WB_IFETCH_ERR_EN adds wb_err and inst_fault.
interface wb_ifetch_if;
    import wb_pkg::*;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    logic              inst_valid;
    logic              inst_ready;
    logic [ADDR_W-1:0] inst_pc;
    logic [DATA_W-1:0] inst_data;

    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_stall;
    logic              wb_ack;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_dat_r;
    logic              wb_we;
    logic [DATA_L-1:0] wb_sel;

`ifdef WB_IFETCH_ERR_EN
    logic              wb_err;
    logic              inst_fault;
`endif

    // The fetch unit itself.
    modport master (
`ifdef WB_IFETCH_ERR_EN
        input  wb_err,
        output inst_fault,
`endif
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_pc, inst_data,
        input  inst_ready,
        output wb_cyc, wb_stb, wb_adr, wb_we, wb_sel,
        input  wb_stall, wb_ack, wb_dat_r
    );

    // Everything around it: the core and the Wishbone slave.
    modport slave (
`ifdef WB_IFETCH_ERR_EN
        output wb_err,
        input  inst_fault,
`endif
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_pc, inst_data,
        output inst_ready,
        input  wb_cyc, wb_stb, wb_adr, wb_we, wb_sel,
        output wb_stall, wb_ack, wb_dat_r
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count, head read straight from storage and
// a flush that empties it in one cycle.
module sync_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_rsp_t
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  T                        push_data_i,
    input  logic                    pop_i,
    output logic                    valid_o,
    output T                        pop_data_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o    = (count_q != '0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/wb_ifetch.sv
// Pipelined Wishbone read master for instruction fetch with credit-based flow control.
// Optional macro WB_IFETCH_ERR_EN: wb_err responses are delivered with inst_fault set.
module wb_ifetch
    import wb_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    wb_ifetch_if.master bus
);

    localparam int            CW      = cnt_w(DEPTH);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_L);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic              redirect;
    logic              accept;
    logic              rsp_in;
    logic              rsp;
    logic              push;
    logic              fire;
    logic              head_valid;
    fetch_rsp_t        push_rsp;
    fetch_rsp_t        head_rsp;

    assign redirect    = bus.redirect_valid;
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};

    // Only request what the FIFO is guaranteed to absorb, so an ack is never lost.
    assign bus.wb_stb = !rst && !redirect && (credit_used < CREDITS);
    assign bus.wb_cyc = bus.wb_stb || (outstanding_q != '0);
    assign bus.wb_adr = fetch_pc_q;
    assign bus.wb_we  = 1'b0;
    assign bus.wb_sel = WB_SEL_ALL;

    assign accept = bus.wb_stb && !bus.wb_stall;

`ifdef WB_IFETCH_ERR_EN
    assign rsp_in = bus.wb_ack || bus.wb_err;
`else
    assign rsp_in = bus.wb_ack;
`endif

    // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
    assign rsp  = rsp_in && (outstanding_q != '0);
    assign push = rsp && (discard_q == '0) && !redirect;
    assign fire = head_valid && bus.inst_ready && !redirect;

    always_comb begin
        push_rsp       = '0;
        push_rsp.pc    = rsp_pc_q;
        push_rsp.data  = bus.wb_dat_r;
`ifdef WB_IFETCH_ERR_EN
        push_rsp.fault = bus.wb_err;
`endif
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);
        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc_d = word_align(bus.redirect_pc);
            rsp_pc_d   = word_align(bus.redirect_pc);
            discard_d  = outstanding_q - CW'(rsp);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + STEP;
            if (rsp) begin
                if (discard_q != '0) discard_d = discard_q - CW'(1);
                else                 rsp_pc_d  = rsp_pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_rsp_t)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_rsp),
        .pop_i       (fire),
        .valid_o     (head_valid),
        .pop_data_o  (head_rsp),
        .count_o     (fifo_count)
    );

    assign bus.inst_valid = head_valid;
    assign bus.inst_pc    = head_rsp.pc;
    assign bus.inst_data  = head_rsp.data;
`ifdef WB_IFETCH_ERR_EN
    assign bus.inst_fault = head_rsp.fault;
`endif

endmodule
